// File: rtl/axi_burst_rom_slave_if.sv
// AXI4 read-address / read-data channels plus the side preload port of the burst ROM.
// Latency: none, wires only.
// Backpressure: AR uses arvalid/arready and R uses rvalid/rready; preload has none.
interface axi_burst_rom_slave_if;
    logic        arready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;
    logic        pl_wen;
    logic [31:0] pl_waddr;
    logic [31:0] pl_wdata;

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  pl_wen, pl_waddr, pl_wdata,
        output arready, rvalid, rresp, rdata, rlast, rid
    );

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output pl_wen, pl_waddr, pl_wdata,
        input  arready, rvalid, rresp, rdata, rlast, rid
    );
endinterface

// File: rtl/axi_burst_rom_slave.sv
// AXI4 read-only burst responder over an internal word array with a side preload port.
// Latency: first rvalid LATENCY+1 cycles after the AR handshake, then one beat per accepted cycle.
// Backpressure: R beat held stable while rready is low; one burst at a time, arready only in IDLE.
// Optional AXI_ROM_RAND_STALL_EN adds LFSR-driven stalls on rvalid and arready.
module axi_burst_rom_slave #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic               clk,
    input  logic               rst,
    axi_burst_rom_slave_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

    logic [31:0] mem_q [DEPTH_WORDS];

    state_t      state_q;
    logic        arready_q;
    logic        rvalid_q;
    logic        rlast_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;
    logic [3:0]  rid_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [8:0]  cnt_q;
    logic [3:0]  wait_q;

    logic [31:0] step_w, bound_w, incr_w, addr_d;
    logic [31:0] beat_off_w, pl_off_w;
    logic [31:0] beat_data_d;
    logic [1:0]  beat_resp_d;
    logic        cfg_err_w, last_hs_w, need_beat_w, present_w;

`ifdef AXI_ROM_RAND_STALL_EN
    logic [7:0] lfsr_q;
    logic [1:0] stall_q;
    logic       stall_arm_q;
`endif

    // Address of the beat after the one being presented; illegal size or reserved burst step as INCR.
    always_comb begin
        step_w  = 32'd1 << size_q;
        bound_w = (32'(len_q) + 32'd1) << size_q;
        incr_w  = addr_q + step_w;
        addr_d  = incr_w;
        if (size_q <= 3'd2) begin
            if (burst_q == 2'b00) begin
                addr_d = addr_q;
            end else if (burst_q == 2'b10) begin
                addr_d = (addr_q & ~(bound_w - 32'd1)) | (incr_w & (bound_w - 32'd1));
            end
        end
    end

    // Per-beat response: burst configuration errors win over address decode; errored beats carry 0.
    always_comb begin
        cfg_err_w   = (burst_q == 2'b11) || (size_q > 3'd2) ||
                      ((burst_q == 2'b10) && !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15}));
        beat_off_w  = addr_q - BASE_ADDR;
        beat_data_d = 32'd0;
        beat_resp_d = 2'b00;
        if (cfg_err_w) begin
            beat_resp_d = 2'b10;
        end else if (beat_off_w >= SPAN) begin
            beat_resp_d = 2'b11;
        end else begin
            beat_data_d = mem_q[beat_off_w[AW+1:2]];
        end
    end

    // Decide whether a new beat goes onto the R channel at the coming edge.
    always_comb begin
        last_hs_w   = rvalid_q && bus.rready && rlast_q;
        need_beat_w = (state_q == S_BEAT) && !last_hs_w && (!rvalid_q || bus.rready);
`ifdef AXI_ROM_RAND_STALL_EN
        present_w   = need_beat_w && (stall_arm_q ? (stall_q == 2'd0) : (lfsr_q[1:0] == 2'd0));
`else
        present_w   = need_beat_w;
`endif
    end

    // Preload writes land in any state; array contents survive reset.
    always_comb pl_off_w = bus.pl_waddr - BASE_ADDR;

    // Preload write port.
    always_ff @(posedge clk) begin
        if (bus.pl_wen && (pl_off_w < SPAN)) begin
            mem_q[pl_off_w[AW+1:2]] <= bus.pl_wdata;
        end
    end

    // Burst FSM with registered AR/R outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'd0;
            rid_q     <= 4'd0;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'b00;
            cnt_q     <= 9'd0;
            wait_q    <= 4'd0;
`ifdef AXI_ROM_RAND_STALL_EN
            lfsr_q      <= 8'hA5;
            stall_q     <= 2'd0;
            stall_arm_q <= 1'b0;
`endif
        end else begin
`ifdef AXI_ROM_RAND_STALL_EN
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.arvalid && arready_q) begin
                        addr_q    <= bus.araddr;
                        rid_q     <= bus.arid;
                        len_q     <= bus.arlen;
                        size_q    <= bus.arsize;
                        burst_q   <= bus.arburst;
                        cnt_q     <= 9'd0;
                        wait_q    <= 4'd0;
                        arready_q <= 1'b0;
                        state_q   <= (LATENCY == 0) ? S_BEAT : S_WAIT;
                    end else begin
`ifdef AXI_ROM_RAND_STALL_EN
                        arready_q <= !(lfsr_q[7] && arready_q);
`else
                        arready_q <= 1'b1;
`endif
                    end
                end
                S_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= S_BEAT;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                S_BEAT: begin
                    if (last_hs_w) begin
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        arready_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (present_w) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= beat_data_d;
                        rresp_q  <= beat_resp_d;
                        rlast_q  <= (cnt_q == {1'b0, len_q});
                        cnt_q    <= cnt_q + 9'd1;
                        addr_q   <= addr_d;
`ifdef AXI_ROM_RAND_STALL_EN
                        stall_arm_q <= 1'b0;
`endif
                    end else if (need_beat_w) begin
                        rvalid_q <= 1'b0;
`ifdef AXI_ROM_RAND_STALL_EN
                        if (stall_arm_q) begin
                            stall_q <= stall_q - 2'd1;
                        end else begin
                            stall_arm_q <= 1'b1;
                            stall_q     <= lfsr_q[1:0] - 2'd1;
                        end
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;
    assign bus.rid     = rid_q;
endmodule

// File: tb/tb_axi_burst_rom_slave.sv
// Directed bench for axi_burst_rom_slave: LATENCY=2 instance for burst types, errors and reset,
// plus a LATENCY=0 instance for back-to-back AR acceptance.
module tb_axi_burst_rom_slave;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_burst_rom_slave_if bus ();
    axi_burst_rom_slave_if bus0 ();

    axi_burst_rom_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    axi_burst_rom_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        bus.pl_wen   = 1'b1;
        bus.pl_waddr = a;
        bus.pl_wdata = d;
        tick();
        bus.pl_wen   = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        bus.araddr  = a;
        bus.arid    = id;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 20) begin
            tick();
            n++;
        end
        check("ar_ready", 32'(bus.arready), 32'd1);
        tick();
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!bus.rvalid && n < max) begin
            tick();
            n++;
        end
    endtask

    // Waits for rvalid, checks the beat, then lets the handshake edge pass (rready must be 1).
    task automatic beat(input string tag, input logic [31:0] d, input logic [1:0] resp,
                        input logic last, input int exp_wait);
        int n;
        wait_valid(20, n);
        check({tag, "_wait"}, 32'(n), 32'(exp_wait));
        check({tag, "_data"}, bus.rdata, d);
        check({tag, "_resp"}, 32'(bus.rresp), 32'(resp));
        check({tag, "_last"}, 32'(bus.rlast), 32'(last));
        tick();
    endtask

    initial begin
        int n;
        bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0;
        bus.arburst = 0; bus.rready = 1; bus.pl_wen = 0; bus.pl_waddr = 0; bus.pl_wdata = 0;
        bus0.arvalid = 0; bus0.araddr = 0; bus0.arid = 0; bus0.arlen = 0; bus0.arsize = 0;
        bus0.arburst = 0; bus0.rready = 1; bus0.pl_wen = 0; bus0.pl_waddr = 0; bus0.pl_wdata = 0;

        // Reset values while reset is held.
        tick();
        tick();
        check("rst_arready", 32'(bus.arready), 32'd1);
        check("rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("rst_rlast",   32'(bus.rlast),   32'd0);
        check("rst_rresp",   32'(bus.rresp),   32'd0);
        check("rst_rdata",   bus.rdata,        32'd0);
        check("rst_rid",     32'(bus.rid),     32'd0);
        rst = 1'b0;
        tick();

        // INCR, len 3, size 2, id 5.
        preload(BASE + 32'd0,  32'd11);
        preload(BASE + 32'd4,  32'd22);
        preload(BASE + 32'd8,  32'd33);
        preload(BASE + 32'd12, 32'd44);
        send_ar(BASE, 4'd5, 8'd3, 3'd2, 2'b01);
        beat("incr_b1", 32'd11, 2'b00, 1'b0, 3);
        check("incr_rid", 32'(bus.rid), 32'd5);
        beat("incr_b2", 32'd22, 2'b00, 1'b0, 0);
        beat("incr_b3", 32'd33, 2'b00, 1'b0, 0);
        beat("incr_b4", 32'd44, 2'b00, 1'b1, 0);
        check("incr_end_rvalid",  32'(bus.rvalid),  32'd0);
        check("incr_end_arready", 32'(bus.arready), 32'd1);

        // WRAP, len 3, start at word 2: 8, C, 0, 4.
        send_ar(BASE + 32'd8, 4'd2, 8'd3, 3'd2, 2'b10);
        beat("wrap_b1", 32'd33, 2'b00, 1'b0, 3);
        beat("wrap_b2", 32'd44, 2'b00, 1'b0, 0);
        beat("wrap_b3", 32'd11, 2'b00, 1'b0, 0);
        beat("wrap_b4", 32'd22, 2'b00, 1'b1, 0);

        // FIXED, len 2, with a 3-cycle rready stall on beat 2.
        send_ar(BASE + 32'd4, 4'd7, 8'd2, 3'd2, 2'b00);
        beat("fix_b1", 32'd22, 2'b00, 1'b0, 3);
        bus.rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("fix_hold_vld",  32'(bus.rvalid), 32'd1);
            check("fix_hold_data", bus.rdata,       32'd22);
            check("fix_hold_last", 32'(bus.rlast),  32'd0);
            tick();
        end
        bus.rready = 1'b1;
        beat("fix_b2", 32'd22, 2'b00, 1'b0, 0);
        beat("fix_b3", 32'd22, 2'b00, 1'b1, 0);

        // Last word then one past the end of the array.
        preload(BASE + 32'hFFC, 32'hDEAD_BEEF);
        send_ar(BASE + 32'hFFC, 4'd1, 8'd1, 3'd2, 2'b01);
        beat("end_b1", 32'hDEAD_BEEF, 2'b00, 1'b0, 3);
        beat("end_b2", 32'd0,         2'b11, 1'b1, 0);

        // Reserved burst type.
        send_ar(BASE, 4'd3, 8'd0, 3'd2, 2'b11);
        beat("rsv_b1", 32'd0, 2'b10, 1'b1, 3);

        // WRAP with illegal length 2: every beat SLVERR.
        send_ar(BASE, 4'd3, 8'd2, 3'd2, 2'b10);
        beat("wlen_b1", 32'd0, 2'b10, 1'b0, 3);
        beat("wlen_b2", 32'd0, 2'b10, 1'b0, 0);
        beat("wlen_b3", 32'd0, 2'b10, 1'b1, 0);

        // Reset during beat 2 of an 8-beat burst.
        send_ar(BASE, 4'd6, 8'd7, 3'd2, 2'b01);
        beat("rstb_b1", 32'd11, 2'b00, 1'b0, 3);
        check("rstb_b2_vld",  32'(bus.rvalid), 32'd1);
        check("rstb_b2_data", bus.rdata,       32'd22);
        rst = 1'b1;
        #1;
        check("rstb_async_rvalid", 32'(bus.rvalid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rstb_arready", 32'(bus.arready), 32'd1);
        check("rstb_rvalid",  32'(bus.rvalid),  32'd0);
        send_ar(BASE + 32'd4, 4'd9, 8'd1, 3'd2, 2'b01);
        beat("post_b1", 32'd22, 2'b00, 1'b0, 3);
        check("post_rid", 32'(bus.rid), 32'd9);
        beat("post_b2", 32'd33, 2'b00, 1'b1, 0);

        // LATENCY=0 instance: second AR held valid, accepted only after the first rlast.
        bus0.pl_wen = 1'b1; bus0.pl_waddr = BASE;         bus0.pl_wdata = 32'd77;
        tick();
        bus0.pl_waddr = BASE + 32'd4; bus0.pl_wdata = 32'd88;
        tick();
        bus0.pl_wen = 1'b0;
        bus0.araddr = BASE; bus0.arid = 4'd3; bus0.arlen = 8'd1; bus0.arsize = 3'd2;
        bus0.arburst = 2'b01; bus0.arvalid = 1'b1;
        check("l0_rdy_idle", 32'(bus0.arready), 32'd1);
        tick();
        check("l0_t0_vld", 32'(bus0.rvalid),  32'd0);
        check("l0_t0_rdy", 32'(bus0.arready), 32'd0);
        bus0.araddr = BASE + 32'd4; bus0.arid = 4'd4; bus0.arlen = 8'd0;
        tick();
        check("l0_t1_vld",  32'(bus0.rvalid),  32'd1);
        check("l0_t1_data", bus0.rdata,        32'd77);
        check("l0_t1_rdy",  32'(bus0.arready), 32'd0);
        tick();
        check("l0_t2_data", bus0.rdata,        32'd88);
        check("l0_t2_last", 32'(bus0.rlast),   32'd1);
        check("l0_t2_rdy",  32'(bus0.arready), 32'd0);
        tick();
        check("l0_t3_vld", 32'(bus0.rvalid),  32'd0);
        check("l0_t3_rdy", 32'(bus0.arready), 32'd1);
        tick();
        check("l0_t4_rdy", 32'(bus0.arready), 32'd0);
        bus0.arvalid = 1'b0;
        tick();
        check("l0_t5_vld",  32'(bus0.rvalid), 32'd1);
        check("l0_t5_data", bus0.rdata,       32'd88);
        check("l0_t5_rid",  32'(bus0.rid),    32'd4);
        check("l0_t5_last", 32'(bus0.rlast),  32'd1);
        tick();
        check("l0_t6_vld", 32'(bus0.rvalid), 32'd0);

        n = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
